// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: default widths and PC stepping.
package inst_prefetch_queue_pkg;
    localparam int InstAddrWidth = 32;
    localparam int InstDataWidth = 32;
    localparam int PcIncrement   = 4;
    localparam int PcAlignBits   = 2;
endpackage

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush and occupancy output; push and pop may coincide, even when full.
module sync_fifo
    import inst_prefetch_queue_pkg::*;
#(
    parameter int WIDTH = InstDataWidth,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop   = pop && (level != '0);
    assign do_push  = push && rst && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, do_pop};
        end
    end

    // Storage carries no reset; the head is only exposed once level says it is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: credit-limited ROM fetch, in-order tag pairing, redirect with stale drop.
// Defining PREFETCH_BYPASS_EN lets a response skip an empty queue in the cycle it arrives.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = InstAddrWidth,
    parameter int                DATA_W   = InstDataWidth,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_req,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic                     rom_gnt,
    input  logic                     rom_rvalid,
    input  logic [DATA_W-1:0]        rom_rdata,
    input  logic                     is_branch,
    input  logic [ADDR_W-1:0]        branch_address,
    input  logic                     inst_ready,
    output logic                     inst_valid,
    output logic [DATA_W-1:0]        inst,
    output logic [ADDR_W-1:0]        pc_plus4,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int CntW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc;
    logic [CntW-1:0]          drop_cnt;
    logic [CntW-1:0]          outstanding;
    logic [CntW-1:0]          fill;
    logic [CntW:0]            credit_used;
    logic [ADDR_W-1:0]        resp_tag;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                     fetch_fire;
    logic                     resp_pop;
    logic                     resp_keep;
    logic                     queue_empty;
    logic                     bypass;
    logic                     push_q;
    logic                     pop_q;

    // Every in-flight fetch reserves a queue slot, so the queue can never overflow.
    assign credit_used = {1'b0, outstanding} + {1'b0, fill};
    assign rom_req     = rst && !is_branch && (credit_used < (CntW+1)'(DEPTH));
    assign rom_addr    = rst ? fetch_pc : RESET_PC;
    assign fetch_fire  = rom_req && rom_gnt;

    assign resp_pop    = rst && rom_rvalid;
    assign resp_keep   = resp_pop && !is_branch && (drop_cnt == '0);
    assign queue_empty = (fill == '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass = resp_keep && queue_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push_q     = resp_keep && !(bypass && inst_ready);
    assign pop_q      = rst && inst_ready && !queue_empty;
    assign fill_level = rst ? fill : '0;

    always_comb begin
        inst_valid = 1'b0;
        inst       = '0;
        pc_plus4   = '0;
        if (rst) begin
            if (bypass) begin
                inst_valid = 1'b1;
                inst       = rom_rdata;
                pc_plus4   = resp_tag;
            end else if (!queue_empty) begin
                inst_valid       = 1'b1;
                {pc_plus4, inst} = head;
            end
        end
    end

    // Drop count is the in-flight total minus any response retired in the redirect cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            if (is_branch) begin
                fetch_pc <= {branch_address[ADDR_W-1:PcAlignBits], {PcAlignBits{1'b0}}};
            end else if (fetch_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(PcIncrement);
            end
            if (is_branch) begin
                drop_cnt <= outstanding - CntW'(rom_rvalid);
            end else if (rom_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Tag queue: its level doubles as the outstanding-fetch count.
    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (fetch_fire),
        .push_data (fetch_pc + ADDR_W'(PcIncrement)),
        .pop       (resp_pop),
        .pop_data  (resp_tag),
        .level     (outstanding)
    );

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (is_branch),
        .push      (push_q),
        .push_data ({resp_tag, rom_rdata}),
        .pop       (pop_q),
        .pop_data  (head),
        .level     (fill)
    );
endmodule
